// File: rtl/hsv2rgb_clk.sv
// Multi-cycle HSV24 -> RGB24 converter that uses one shared restoring divider by 15300 (255*60).
// Define HSV2RGB_ROUND_EN to round quotients half-up instead of truncating them.
//   state   | meaning
//   S_IDLE  | wait for enable, latch clamped H, S, V
//   S_PREP  | hue sector/fraction and the three dividends
//   S_DIV   | 24 cycles: p, q, t quotients, 8 bits each
//   S_DONE  | map to RGB by sector, pulse rgb_done
//   S_READY | drop rgb_done, refuse requests
module hsv2rgb_clk #(
  parameter logic [7:0] HUE_MAX = 8'd179
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        enable,
  input  logic [23:0] HSV24,
  output logic [23:0] RGB24,
  output logic        rgb_done
);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_DIV, S_DONE, S_READY} state_t;

  localparam logic [21:0] K     = 22'd15300;
  localparam logic [21:0] K_TOP = K << 7;
`ifdef HSV2RGB_ROUND_EN
  localparam logic [21:0] RND   = 22'd7650;
`else
  localparam logic [21:0] RND   = 22'd0;
`endif

  state_t      state;
  logic [7:0]  h_r, s_r, v_r;
  logic [2:0]  sector_r;
  logic [21:0] dq_r, dt_r;
  logic [21:0] rem, dsh;
  logic [7:0]  quo, p_r, q_r, t_r;
  logic [2:0]  bit_cnt;
  logic [1:0]  sel;

  logic [8:0]  h2_c;
  logic [2:0]  sector_c;
  logic [5:0]  f_c;
  logic [13:0] sf_c, st_c;
  logic [21:0] dp_c, dq_c, dt_c, rem_c;
  logic        ge_c;
  logic [7:0]  quo_c;

  always_comb begin
    h2_c     = {h_r, 1'b0};
    sector_c = 3'(h2_c / 9'd60);
    f_c      = 6'(h2_c % 9'd60);
    sf_c     = 14'(s_r) * 14'(f_c);
    st_c     = 14'(s_r) * (14'd60 - 14'(f_c));
    dp_c     = 22'(v_r) * 22'(8'd255 - s_r) * 22'd60 + RND;
    dq_c     = 22'(v_r) * (K - 22'(sf_c)) + RND;
    dt_c     = 22'(v_r) * (K - 22'(st_c)) + RND;
    // One restoring step: the divisor is pre-shifted, so the remainder never moves.
    ge_c     = (rem >= dsh);
    rem_c    = ge_c ? (rem - dsh) : rem;
    quo_c    = {quo[6:0], ge_c};
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state    <= S_IDLE;
      RGB24    <= 24'd0;
      rgb_done <= 1'b0;
      h_r      <= 8'd0;
      s_r      <= 8'd0;
      v_r      <= 8'd0;
      sector_r <= 3'd0;
      dq_r     <= 22'd0;
      dt_r     <= 22'd0;
      rem      <= 22'd0;
      dsh      <= 22'd0;
      quo      <= 8'd0;
      p_r      <= 8'd0;
      q_r      <= 8'd0;
      t_r      <= 8'd0;
      bit_cnt  <= 3'd0;
      sel      <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          rgb_done <= 1'b0;
          if (enable) begin
            h_r   <= (HSV24[23:16] > HUE_MAX) ? HUE_MAX : HSV24[23:16];
            s_r   <= HSV24[15:8];
            v_r   <= HSV24[7:0];
            state <= S_PREP;
          end
        end
        S_PREP: begin
          sector_r <= sector_c;
          rem      <= dp_c;
          dq_r     <= dq_c;
          dt_r     <= dt_c;
          dsh      <= K_TOP;
          bit_cnt  <= 3'd7;
          sel      <= 2'd0;
          state    <= S_DIV;
        end
        S_DIV: begin
          if (bit_cnt == 3'd0) begin
            dsh     <= K_TOP;
            bit_cnt <= 3'd7;
            sel     <= sel + 2'd1;
            case (sel)
              2'd0: begin p_r <= quo_c; rem <= dq_r; end
              2'd1: begin q_r <= quo_c; rem <= dt_r; end
              default: begin t_r <= quo_c; state <= S_DONE; end
            endcase
          end else begin
            rem     <= rem_c;
            dsh     <= dsh >> 1;
            quo     <= quo_c;
            bit_cnt <= bit_cnt - 3'd1;
          end
        end
        S_DONE: begin
          if (s_r == 8'd0) RGB24 <= {v_r, v_r, v_r};
          else begin
            case (sector_r)
              3'd0:    RGB24 <= {v_r, t_r, p_r};
              3'd1:    RGB24 <= {q_r, v_r, p_r};
              3'd2:    RGB24 <= {p_r, v_r, t_r};
              3'd3:    RGB24 <= {p_r, q_r, v_r};
              3'd4:    RGB24 <= {t_r, p_r, v_r};
              default: RGB24 <= {v_r, p_r, q_r};
            endcase
          end
          rgb_done <= 1'b1;
          state    <= S_READY;
        end
        S_READY: begin
          rgb_done <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
